priority_desk_dispatcher: RTL and testbench

- Downstream consumer of the ticket queue. Watches the regular ticket total from the queue and a second priority ticket total.
- Assigns the next waiting ticket to whichever service desk asks for one, with priority tickets first and an anti-starvation rule for regular tickets.
- Announces each call on a call bus for the display.
- Emits one-cycle Done / Prio_Done pulses that advance the upstream queues' current-client counters.

---
 rtl/priority_desk_dispatcher.sv | 185 ++++++++++++++++++
 tb/tb_priority_desk_dispatcher.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_desk_dispatcher.sv
// Ticket-to-desk dispatcher: priority tickets first with a starvation guard for
// regular tickets, round-robin desk choice, and one call announced every two cycles.
module priority_desk_dispatcher #(
    parameter int NUM_DESKS    = 4,
    parameter int TICKET_W     = 8,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [TICKET_W-1:0]  Total_Clients,
    input  logic [TICKET_W-1:0]  Prio_Total,
    input  logic [NUM_DESKS-1:0] Desk_Req,
    output logic [NUM_DESKS-1:0] Desk_Busy,
    output logic [NUM_DESKS-1:0] Desk_Wait,
    output logic                 Call_Valid,
    output logic [2:0]           Call_Desk,
    output logic [TICKET_W-1:0]  Call_Ticket,
    output logic                 Call_Prio,
    output logic                 Done,
    output logic                 Prio_Done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ANNOUNCE
    } state_t;

    localparam int                   STARVE_W   = $clog2(STARVE_LIMIT + 2);
    localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [2:0]           LAST_DESK  = 3'(NUM_DESKS - 1);

    state_t                state;
    logic [TICKET_W-1:0]   reg_served;
    logic [TICKET_W-1:0]   prio_served;
    logic [STARVE_W-1:0]   starve_cnt;
    logic [2:0]            rr_ptr;
    logic [NUM_DESKS-1:0]  desk_wait;
    logic [NUM_DESKS-1:0]  desk_busy;

    logic                  reg_avail;
    logic                  prio_avail;
    logic                  reg_resync;
    logic                  prio_resync;
    logic                  work_ready;
    logic                  found;
    logic [2:0]            win_idx;
    logic                  pick_prio;
    logic                  pick_reg;
    logic                  grant_fire;
    logic [TICKET_W-1:0]   reg_next;
    logic [TICKET_W-1:0]   prio_next;

    // A total below its served count means the upstream queue was reset.
    assign reg_resync  = Total_Clients < reg_served;
    assign prio_resync = Prio_Total < prio_served;
    assign reg_avail   = Total_Clients > reg_served;
    assign prio_avail  = Prio_Total > prio_served;
    assign work_ready  = (|desk_wait) && (reg_avail || prio_avail);

    assign reg_next  = reg_served + TICKET_W'(1);
    assign prio_next = prio_served + TICKET_W'(1);

    // Priority wins unless regular tickets have waited through STARVE_LIMIT priority calls.
    assign pick_prio  = prio_avail && !(reg_avail && (starve_cnt == STARVE_MAX));
    assign pick_reg   = !pick_prio && reg_avail;
    assign grant_fire = (state == ST_GRANT) && found && (pick_prio || pick_reg);

    // Round-robin scan: first the desks at or above the pointer, then wrap to the bottom.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a default
        // first, so no path leaves a value unassigned and no latch is inferred.
        found   = 1'b0;
        win_idx = '0;
        for (int d = 0; d < NUM_DESKS; d++) begin
            if (!found && desk_wait[d] && (3'(d) >= rr_ptr)) begin
                found   = 1'b1;
                win_idx = 3'(d);
            end
        end
        for (int d = 0; d < NUM_DESKS; d++) begin
            if (!found && desk_wait[d]) begin
                found   = 1'b1;
                win_idx = 3'(d);
            end
        end
    end

    // Per-desk request latch; the granted desk has its Wait bit set, so its own
    // request pulse can never collide with the grant.
    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: clocked state uses non-blocking '<=' so every register samples
        // pre-edge values regardless of statement order.
        if (!Reset_n) begin
            desk_wait <= '0;
            desk_busy <= '0;
        end else begin
            for (int d = 0; d < NUM_DESKS; d++) begin
                if (grant_fire && (win_idx == 3'(d))) begin
                    desk_wait[d] <= 1'b0;
                    desk_busy[d] <= 1'b1;
                end else if (Desk_Req[d] && !desk_wait[d]) begin
                    desk_wait[d] <= 1'b1;
                    desk_busy[d] <= 1'b0;
                end
            end
        end
    end

    assign Desk_Wait = desk_wait;
    assign Desk_Busy = desk_busy;

    // Dispatch FSM with served counters, starvation counter and registered call bus.
    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: every register here, including the call bus, is cleared by the async
        // reset so an interrupted announce cannot leave a strobe or stale call behind.
        if (!Reset_n) begin
            state       <= ST_IDLE;
            reg_served  <= '0;
            prio_served <= '0;
            starve_cnt  <= '0;
            rr_ptr      <= '0;
            Call_Valid  <= 1'b0;
            Call_Desk   <= '0;
            Call_Ticket <= '0;
            Call_Prio   <= 1'b0;
            Done        <= 1'b0;
            Prio_Done   <= 1'b0;
        end else begin
            Call_Valid <= 1'b0;
            Done       <= 1'b0;
            Prio_Done  <= 1'b0;

            if (reg_resync) begin
                reg_served <= '0;
            end else if (grant_fire && pick_reg) begin
                reg_served <= reg_next;
            end

            if (prio_resync) begin
                prio_served <= '0;
            end else if (grant_fire && pick_prio) begin
                prio_served <= prio_next;
            end

            case (state)
                ST_IDLE: begin
                    if (work_ready) begin
                        state <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    if (grant_fire) begin
                        Call_Desk   <= win_idx;
                        Call_Ticket <= pick_prio ? prio_next : reg_next;
                        Call_Prio   <= pick_prio;
                        Call_Valid  <= 1'b1;
                        Done        <= pick_reg;
                        Prio_Done   <= pick_prio;
                        rr_ptr      <= (win_idx == LAST_DESK) ? 3'd0 : win_idx + 3'd1;
                        if (pick_prio && reg_avail) begin
                            starve_cnt <= starve_cnt + STARVE_W'(1);
                        end else begin
                            starve_cnt <= '0;
                        end
                        state <= ST_ANNOUNCE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                // Chaining straight back to GRANT keeps one call per two cycles.
                ST_ANNOUNCE: begin
                    state <= work_ready ? ST_GRANT : ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_priority_desk_dispatcher.sv
// Randomised and directed bench for priority_desk_dispatcher: a transaction-level
// model predicts every call into a queue that a negedge monitor drains and compares.
module tb_priority_desk_dispatcher;

    localparam int ND = 4;
    localparam int TW = 8;
    localparam int SL = 3;
    localparam int IW = $clog2(ND);

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic [TW-1:0] Total_Clients = '0;
    logic [TW-1:0] Prio_Total = '0;
    logic [ND-1:0] Desk_Req = '0;
    logic [ND-1:0] Desk_Busy;
    logic [ND-1:0] Desk_Wait;
    logic          Call_Valid;
    logic [2:0]    Call_Desk;
    logic [TW-1:0] Call_Ticket;
    logic          Call_Prio;
    logic          Done;
    logic          Prio_Done;

    priority_desk_dispatcher #(
        .NUM_DESKS   (ND),
        .TICKET_W    (TW),
        .STARVE_LIMIT(SL)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Total_Clients(Total_Clients),
        .Prio_Total   (Prio_Total),
        .Desk_Req     (Desk_Req),
        .Desk_Busy    (Desk_Busy),
        .Desk_Wait    (Desk_Wait),
        .Call_Valid   (Call_Valid),
        .Call_Desk    (Call_Desk),
        .Call_Ticket  (Call_Ticket),
        .Call_Prio    (Call_Prio),
        .Done         (Done),
        .Prio_Done    (Prio_Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int desk;
        int ticket;
        bit prio;
    } call_t;

    call_t exp_q[$];
    int    seen_desk[$];
    int    seen_ticket[$];
    bit    seen_prio[$];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int pdone_cnt = 0;
    bit mon_en = 1'b0;

    // Reference model: plain counters and desk sets.
    int            m_reg;
    int            m_prio;
    int            m_starve;
    int            m_rr;
    logic [ND-1:0] m_wait;
    logic [ND-1:0] m_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_reg    = 0;
        m_prio   = 0;
        m_starve = 0;
        m_rr     = 0;
        m_wait   = '0;
        m_busy   = '0;
        exp_q.delete();
    endtask

    // Applies one stimulus step and predicts every call that follows from it.
    task automatic model_phase(input int tot, input int ptot, input logic [ND-1:0] req,
                               output int n, output bit rs);
        int d;
        int rp;
        int pp;
        bit up;
        rs = 1'b0;
        n  = 0;
        if (tot < m_reg) begin
            m_reg = 0;
            rs    = 1'b1;
        end
        if (ptot < m_prio) begin
            m_prio = 0;
            rs     = 1'b1;
        end
        for (int k = 0; k < ND; k++) begin
            if (req[IW'(k)] && !m_wait[IW'(k)]) begin
                m_wait[IW'(k)] = 1'b1;
                m_busy[IW'(k)] = 1'b0;
            end
        end
        while (m_wait != '0 && (tot > m_reg || ptot > m_prio)) begin
            d = m_rr;
            while (!m_wait[IW'(d)]) d = (d + 1) % ND;
            rp = tot - m_reg;
            pp = ptot - m_prio;
            up = (pp > 0) && !(rp > 0 && m_starve == SL);
            if (up) begin
                m_prio++;
                m_starve = (rp > 0) ? m_starve + 1 : 0;
                exp_q.push_back('{desk: d, ticket: m_prio, prio: 1'b1});
            end else begin
                m_reg++;
                m_starve = 0;
                exp_q.push_back('{desk: d, ticket: m_reg, prio: 1'b0});
            end
            m_wait[IW'(d)] = 1'b0;
            m_busy[IW'(d)] = 1'b1;
            m_rr = (d + 1) % ND;
            n++;
        end
    endtask

    // Monitor: compares each announced call against the head of the queue.
    always @(negedge Clk) begin
        if (Reset_n && mon_en) begin
            if (Done) done_cnt++;
            if (Prio_Done) pdone_cnt++;
            if (Call_Valid) begin
                call_t         e;
                logic [ND-1:0] bmask;
                check("call_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e     = exp_q.pop_front();
                    bmask = ND'(1) << e.desk;
                    check("call_desk", 32'(Call_Desk), e.desk);
                    check("call_ticket", 32'(Call_Ticket), e.ticket);
                    check("call_prio", 32'(Call_Prio), 32'(e.prio));
                    check("done_pulse", 32'(Done), 32'(!e.prio));
                    check("prio_done_pulse", 32'(Prio_Done), 32'(e.prio));
                    check("winner_busy", 32'(Desk_Busy & bmask), 32'(bmask));
                end
                seen_desk.push_back(int'(Call_Desk));
                seen_ticket.push_back(int'(Call_Ticket));
                seen_prio.push_back(Call_Prio);
            end else if (Done || Prio_Done) begin
                check("stray_done", 32'({Done, Prio_Done}), 32'd0);
            end
        end
    end

    task automatic reset_dut();
        mon_en        = 1'b0;
        Reset_n       = 1'b0;
        Desk_Req      = '0;
        Total_Clients = '0;
        Prio_Total    = '0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        seen_desk.delete();
        seen_ticket.delete();
        seen_prio.delete();
        done_cnt  = 0;
        pdone_cnt = 0;
        mon_en    = 1'b1;
    endtask

    // Drives one stimulus step from a quiet DUT and waits for the predicted calls.
    task automatic phase(input int tot, input int ptot, input logic [ND-1:0] req);
        int n;
        bit rs;
        bit had_wait;
        int prev;
        had_wait = (m_wait != '0);
        @(negedge Clk);
        Total_Clients = TW'(tot);
        Prio_Total    = TW'(ptot);
        Desk_Req      = req;
        model_phase(tot, ptot, req, n, rs);
        prev = -1;
        for (int c = 1; c <= 2 * n + 8; c++) begin
            @(negedge Clk);
            if (c == 1) Desk_Req = '0;
            if (Call_Valid) begin
                if (prev < 0) begin
                    if (!rs) check("call_latency", c, had_wait ? 2 : 3);
                end else begin
                    check("call_spacing", c - prev, 2);
                end
                prev = c;
            end
        end
        check("queue_drained", exp_q.size(), 0);
        check("desk_wait", 32'(Desk_Wait), 32'(m_wait));
        check("desk_busy", 32'(Desk_Busy), 32'(m_busy));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rt;
        int  pt;
        int  hits;
        bit  seen;
        logic [6:0] exp_cls;

        // Reset asserted while a call is being announced.
        reset_dut();
        mon_en        = 1'b0;
        Total_Clients = TW'(1);
        @(negedge Clk);
        Desk_Req = ND'(1);
        @(negedge Clk);
        Desk_Req = '0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge Clk);
            #1;
            if (Call_Valid) seen = 1'b1;
        end
        check("rst_call_seen", 32'(seen), 32'd1);
        Reset_n = 1'b0;
        #1;
        check("rst_outputs_zero",
              32'({Desk_Busy, Desk_Wait, Call_Valid, Call_Desk, Call_Ticket, Call_Prio, Done, Prio_Done}),
              32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        hits = 0;
        repeat (6) begin
            @(negedge Clk);
            if (Done || Prio_Done || Call_Valid) hits++;
        end
        check("rst_no_pulse_after", hits, 0);
        model_reset();
        mon_en = 1'b1;

        // Single regular ticket to desk 2; served counters restart at 0 after reset.
        phase(1, 0, 4'b0100);
        check("single_ticket", seen_ticket.size() == 1 ? seen_ticket[0] : -1, 1);
        check("single_done_cnt", done_cnt, 1);

        // Priority first with the starvation guard.
        reset_dut();
        phase(2, 5, 4'b1111);
        phase(2, 5, 4'b1111);
        exp_cls = 7'b1110110;
        check("starve_calls", seen_prio.size(), 7);
        for (int i = 0; i < 7 && i < seen_prio.size(); i++) begin
            check("starve_class", 32'(seen_prio[i]), 32'(exp_cls[6-i]));
        end
        check("starve_done_cnt", done_cnt, 2);
        check("starve_prio_done_cnt", pdone_cnt, 5);

        // Round-robin over a simultaneous request from every desk.
        reset_dut();
        phase(4, 0, 4'b1111);
        check("rr_calls", seen_desk.size(), 4);
        for (int i = 0; i < 4 && i < seen_desk.size(); i++) begin
            check("rr_desk", seen_desk[i], i);
            check("rr_ticket", seen_ticket[i], i + 1);
        end

        // Request with no tickets waits, then is served when a ticket appears.
        reset_dut();
        phase(0, 0, 4'b0010);
        check("notix_wait", 32'(Desk_Wait), 32'b0010);
        check("notix_no_call", seen_desk.size(), 0);
        phase(1, 0, 4'b0000);
        check("notix_served", seen_desk.size() == 1 ? seen_desk[0] : -1, 1);

        // Upstream queue reset drops the total below the served count.
        reset_dut();
        phase(3, 0, 4'b0111);
        phase(0, 0, 4'b0000);
        check("resync_no_call", seen_ticket.size(), 3);
        phase(1, 0, 4'b1000);
        check("resync_ticket", seen_ticket.size() == 4 ? seen_ticket[3] : -1, 1);

        // Randomised traffic including occasional upstream resets.
        reset_dut();
        rt = 0;
        pt = 0;
        repeat (40) begin
            if ($urandom_range(0, 9) == 0) rt = $urandom_range(0, rt);
            else rt = (rt + $urandom_range(0, 3) > 100) ? 100 : rt + $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) pt = $urandom_range(0, pt);
            else pt = (pt + $urandom_range(0, 2) > 100) ? 100 : pt + $urandom_range(0, 2);
            phase(rt, pt, ND'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
